proc_mem_io: RTL and testbench
==============================

// Module: proc_mem_io
// PURPOSE
//  Downstream memory/IO stage of the 16-bit multicycle processor. Consumes the processor's
//  registered ADDR, DOUT and W, and returns read data on DIN. Holds the program/data RAM,
//  an LED output register, four HEX digit registers and a programmable delay timer.
// PARAMETERS
//  RAM_AW        7       RAM address width; depth is 2**RAM_AW words of 16 bits
//  TIMER_PRESC   50000   clocks per timer tick; legal range >= 1
// PORTS
//  Clock     in   1    single clock, rising edge
//  Resetn    in   1    reset, synchronous, active-low
//  ADDR      in   16   processor address register
//  DOUT      in   16   processor write-data register
//  W         in   1    write strobe; a write occurs on every rising edge with W=1
//  DIN       out  16   read data returned to the processor
//  LEDR      out  9    LED register
//  HEX0..3   out  7    segment patterns, one per digit; written raw, not decoded
//  TMR_IRQ   out  1    copy of the timer done flag
// BEHAVIOUR
//  Address map (region = ADDR[15:12]):
//   0x0 RAM: word index ADDR[RAM_AW-1:0]; higher ADDR bits in the region are ignored
//   0x1 LEDR: write takes DOUT[8:0]; read returns {7'b0,LEDR}
//   0x2 HEX: ADDR[1:0] selects the digit; write takes DOUT[6:0]; read returns {9'b0,HEXn}
//   0x3 timer: ADDR[0]=0 COUNT; ADDR[0]=1 STATUS (bit0 = done)
//   other regions: reads return 16'h0000; writes are ignored
//  Read latency is 1 clock. DIN is registered: at each edge DIN <= data[ADDR]. A write and
//   a read of the same address on the same edge return the OLD value (read-before-write).
//  RAM is not reset; contents are undefined until written or until the init file loads.
//  Reset (Resetn=0 at an edge) clears the following: DIN, LEDR, HEX0..3, COUNT, the
//   prescaler, done and TMR_IRQ all go to 0. Reset mid-countdown aborts the countdown.
//  Timer states:
//   IDLE (COUNT=0):
//    - a write of COUNT=N with N!=0 loads COUNT=N and prescaler=TIMER_PRESC-1 -> RUN
//    - a write of 0 keeps the timer in IDLE and does not set done
//   RUN:
//    - the prescaler decrements every clock
//    - when the prescaler is 0: it reloads and COUNT decrements
//    - when COUNT goes from 1 to 0: done <= 1 and the timer returns to IDLE
//    - a write of COUNT while in RUN reloads COUNT and the prescaler (restart); done is unchanged
//    - a load on the same edge as an expiry: the load wins and done is not set
//   STATUS write (any data): clears done
//    - if the clear coincides with an expiry edge, the set wins (done=1)
//   Reads:
//    - COUNT read returns the live COUNT
//    - STATUS read returns {15'b0,done}
//  TMR_IRQ equals done, registered; there is no additional latency.
// STRUCTURE
//  proc_io_pkg (shared package) holds:
//   - region codes REG_RAM=4'h0, REG_LED=4'h1, REG_HEX=4'h2, REG_TMR=4'h3
//   - timer offsets TMR_COUNT=1'b0, TMR_STATUS=1'b1
//  Sub-module io_timer (prescaler, COUNT, done; load/clear/expiry priority) is instantiated once.
//  Region decode, RAM array, LED/HEX registers and the DIN read mux live in the top level.
// TESTING
//  1 Write 0x1234 to 0x0005, then read 0x0005 -> DIN=0x1234 one clock after ADDR is applied.
//  2 Write 0x01FF to 0x1000, read 0x1000 -> LEDR=0x1FF and DIN=0x01FF. Write 0x5A to 0x2002
//    -> HEX2=7'h5A; HEX0, HEX1 and HEX3 are unchanged.
//  3 Use TIMER_PRESC=4 and write 3 to 0x3000 -> done=1 exactly 12 clocks later.
//    COUNT reads 3,2,1,0 over that window. A write to 0x3001 then gives done=0.
//  4 Timer collisions: a COUNT load on the expiry edge -> done stays 0 and the countdown
//    restarts. A STATUS clear on the expiry edge -> done=1.
//  5 Read of 0x7000 -> DIN=0x0000; a write to 0x7000 changes no state. Same-edge write and
//    read of RAM 0x0003 -> DIN shows the old data, and the next read shows the new data.
//  6 Resetn=0 for one edge mid-countdown with LEDR=0x1FF -> LEDR, HEX, COUNT, done and DIN
//    all read 0 afterwards, and the timer stays in IDLE.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared constants for the processor memory/IO stage: region codes and timer register offsets.
package proc_io_pkg;

  localparam logic [3:0] REG_RAM = 4'h0;
  localparam logic [3:0] REG_LED = 4'h1;
  localparam logic [3:0] REG_HEX = 4'h2;
  localparam logic [3:0] REG_TMR = 4'h3;

  localparam logic TMR_COUNT  = 1'b0;
  localparam logic TMR_STATUS = 1'b1;

endpackage

// File: rtl/io_timer.sv
// Programmable delay timer: a prescaler paces COUNT down to zero, then the sticky done flag is set.
module io_timer #(
  parameter int unsigned TIMER_PRESC = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic        status_we_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] count_o,
  output logic        done_o
);

  localparam int unsigned PW = (TIMER_PRESC > 1) ? $clog2(TIMER_PRESC) : 1;
  localparam logic [PW-1:0] Reload = PW'(TIMER_PRESC - 1);

  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          expire;

  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    done_d  = done_q;
    expire  = 1'b0;
    // COUNT == 0 is the idle state; nothing moves until a non-zero load.
    if (count_q != 16'd0) begin
      if (presc_q == '0) begin
        presc_d = Reload;
        count_d = count_q - 16'd1;
        expire  = (count_q == 16'd1);
      end else begin
        presc_d = presc_q - PW'(1);
      end
    end
    if (status_we_i) done_d = 1'b0;
    if (expire)      done_d = 1'b1;
    // A load overrides an expiry on the same edge and leaves done untouched.
    if (count_we_i) begin
      count_d = wdata_i;
      presc_d = Reload;
      done_d  = done_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;

endmodule

// File: rtl/proc_mem_io.sv
// Memory/IO stage of the 16-bit multicycle processor: RAM, LED and HEX registers, delay timer,
// and a registered read-before-write DIN mux.
module proc_mem_io
  import proc_io_pkg::*;
#(
  parameter int unsigned RAM_AW      = 7,
  parameter int unsigned TIMER_PRESC = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  output logic [8:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        TMR_IRQ
);

  logic [3:0]       region;
  logic             we_ram, we_led, we_hex, we_cnt, we_sts;
  logic [15:0]      ram_q [2**RAM_AW];
  logic [8:0]       led_q;
  logic [3:0][6:0]  hex_q;
  logic [15:0]      din_q, rdata;
  logic [15:0]      tmr_count;
  logic             tmr_done;
  logic             unused_addr;

  assign region      = ADDR[15:12];
  assign unused_addr = ^ADDR;
  assign we_ram      = W && (region == REG_RAM);
  assign we_led      = W && (region == REG_LED);
  assign we_hex      = W && (region == REG_HEX);
  assign we_cnt      = W && (region == REG_TMR) && (ADDR[0] == TMR_COUNT);
  assign we_sts      = W && (region == REG_TMR) && (ADDR[0] == TMR_STATUS);

  io_timer #(
    .TIMER_PRESC(TIMER_PRESC)
  ) u_timer (
    .clk_i      (Clock),
    .rst_ni     (Resetn),
    .count_we_i (we_cnt),
    .status_we_i(we_sts),
    .wdata_i    (DOUT),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  // RAM is deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (we_ram) ram_q[ADDR[RAM_AW-1:0]] <= DOUT;
  end

  always_comb begin
    rdata = 16'h0000;
    case (region)
      REG_RAM: rdata = ram_q[ADDR[RAM_AW-1:0]];
      REG_LED: rdata = {7'b0, led_q};
      REG_HEX: rdata = {9'b0, hex_q[ADDR[1:0]]};
      REG_TMR: rdata = (ADDR[0] == TMR_STATUS) ? {15'b0, tmr_done} : tmr_count;
      default: rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      din_q <= '0;
      led_q <= '0;
      hex_q <= '0;
    end else begin
      din_q <= rdata;
      if (we_led) led_q <= DOUT[8:0];
      if (we_hex) hex_q[ADDR[1:0]] <= DOUT[6:0];
    end
  end

  assign DIN     = din_q;
  assign LEDR    = led_q;
  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign TMR_IRQ = tmr_done;

endmodule

// File: tb/tb_proc_mem_io.sv
// Bench for proc_mem_io: directed table, timer corner sequences and random traffic vs a model.
module tb_proc_mem_io;

  localparam int P = 4;

  logic        Clock, Resetn, W, TMR_IRQ;
  logic [15:0] ADDR, DOUT, DIN;
  logic [8:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  proc_mem_io #(.RAM_AW(7), .TIMER_PRESC(P)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .ADDR   (ADDR),
    .DOUT   (DOUT),
    .W      (W),
    .DIN    (DIN),
    .LEDR   (LEDR),
    .HEX0   (HEX0),
    .HEX1   (HEX1),
    .HEX2   (HEX2),
    .HEX3   (HEX3),
    .TMR_IRQ(TMR_IRQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [15:0] m_ram [128];
  bit          m_rv  [128];
  logic [8:0]  m_led;
  logic [6:0]  m_hex [4];
  logic [15:0] m_din;
  bit          m_din_v;
  bit          t_act;
  int          t_n, t_k;
  bit          m_done;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Timer modelled as elapsed cycles since load: COUNT = N - elapsed/P, done at elapsed = N*P.
  function automatic logic [15:0] m_count();
    return t_act ? 16'(t_n - t_k / P) : 16'h0;
  endfunction

  task automatic model_edge(input logic [15:0] a, input logic [15:0] d, input logic w,
                            input logic rn);
    logic [15:0] rd;
    bit          rdv, load, expire;
    if (!rn) begin
      m_led = '0;
      for (int i = 0; i < 4; i++) m_hex[i] = '0;
      m_din = '0; m_din_v = 1; t_act = 0; m_done = 0;
      return;
    end
    rdv = 1;
    case (a[15:12])
      4'h0: begin rd = m_ram[a[6:0]]; rdv = m_rv[a[6:0]]; end
      4'h1: rd = {7'b0, m_led};
      4'h2: rd = {9'b0, m_hex[a[1:0]]};
      4'h3: rd = a[0] ? {15'b0, m_done} : m_count();
      default: rd = '0;
    endcase
    load   = w && (a[15:12] == 4'h3) && !a[0];
    expire = t_act && (t_k + 1 == t_n * P);
    if (load) begin
      t_act = (d != 0); t_n = int'(d); t_k = 0;
    end else if (t_act) begin
      t_k++;
      if (expire) t_act = 0;
    end
    if (!load && expire) m_done = 1;
    else if (w && (a[15:12] == 4'h3) && a[0]) m_done = 0;
    if (w) begin
      case (a[15:12])
        4'h0: begin m_ram[a[6:0]] = d; m_rv[a[6:0]] = 1; end
        4'h1: m_led = d[8:0];
        4'h2: m_hex[a[1:0]] = d[6:0];
        default: ;
      endcase
    end
    m_din = rd; m_din_v = rdv;
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                      input logic rn);
    ADDR = a; DOUT = d; W = w; Resetn = rn;
    @(posedge Clock);
    model_edge(a, d, w, rn);
    #1;
    if (m_din_v) chk("din", DIN, m_din);
    chk("ledr", {7'b0, LEDR}, {7'b0, m_led});
    chk("hex0", {9'b0, HEX0}, {9'b0, m_hex[0]});
    chk("hex1", {9'b0, HEX1}, {9'b0, m_hex[1]});
    chk("hex2", {9'b0, HEX2}, {9'b0, m_hex[2]});
    chk("hex3", {9'b0, HEX3}, {9'b0, m_hex[3]});
    chk("irq", {15'b0, TMR_IRQ}, {15'b0, m_done});
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic        chk_din;
    logic [15:0] exp_din;
    logic [8:0]  exp_led;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] a, d;
    logic        w;
    tbl.push_back('{16'h0005, 16'h1234, 1'b1, 1'b0, 16'h0000, 9'h000});
    tbl.push_back('{16'h0005, 16'h0000, 1'b0, 1'b1, 16'h1234, 9'h000});
    tbl.push_back('{16'h1000, 16'h01FF, 1'b1, 1'b1, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h1000, 16'h0000, 1'b0, 1'b1, 16'h01FF, 9'h1FF});
    tbl.push_back('{16'h2002, 16'h005A, 1'b1, 1'b1, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h2002, 16'h0000, 1'b0, 1'b1, 16'h005A, 9'h1FF});
    tbl.push_back('{16'h2000, 16'h0000, 1'b0, 1'b1, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h2001, 16'h00FF, 1'b1, 1'b1, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h2001, 16'h0000, 1'b0, 1'b1, 16'h007F, 9'h1FF});
    tbl.push_back('{16'h7000, 16'h0000, 1'b0, 1'b1, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h7000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h1000, 16'h0000, 1'b0, 1'b1, 16'h01FF, 9'h1FF});
    tbl.push_back('{16'h0003, 16'h1111, 1'b1, 1'b0, 16'h0000, 9'h1FF});
    tbl.push_back('{16'h0003, 16'h2222, 1'b1, 1'b1, 16'h1111, 9'h1FF});
    tbl.push_back('{16'h0003, 16'h0000, 1'b0, 1'b1, 16'h2222, 9'h1FF});
    tbl.push_back('{16'h0F85, 16'h0000, 1'b0, 1'b1, 16'h1234, 9'h1FF});

    for (int i = 0; i < 128; i++) m_rv[i] = 0;
    m_din_v = 0;
    ADDR = '0; DOUT = '0; W = 0; Resetn = 0;
    step(16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("reset_din", DIN, 16'h0000);
    chk("reset_irq", {15'b0, TMR_IRQ}, 16'h0000);

    foreach (tbl[i]) begin
      step(tbl[i].addr, tbl[i].dout, tbl[i].w, 1'b1);
      if (tbl[i].chk_din) chk($sformatf("tbl%0d_din", i), DIN, tbl[i].exp_din);
      chk($sformatf("tbl%0d_led", i), {7'b0, LEDR}, {7'b0, tbl[i].exp_led});
    end
    chk("hex2_raw", {9'b0, HEX2}, 16'h005A);
    chk("hex3_kept", {9'b0, HEX3}, 16'h0000);

    // Countdown of 3 with prescale 4: done exactly 12 clocks after the load.
    step(16'h3000, 16'd3, 1'b1, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      step(16'h3000, 16'h0000, 1'b0, 1'b1);
      if (k <= 12) begin
        chk("t3_irq", {15'b0, TMR_IRQ}, (k == 12) ? 16'd1 : 16'd0);
        chk("t3_count", DIN, 16'(3 - (k - 1) / 4));
      end else begin
        chk("t3_count_end", DIN, 16'h0000);
      end
    end
    step(16'h3001, 16'hBEEF, 1'b1, 1'b1);
    chk("t3_clear", {15'b0, TMR_IRQ}, 16'h0000);

    // Load on the expiry edge: done stays low, new countdown of 2 runs 8 clocks.
    step(16'h3000, 16'd1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(16'h1000, 16'h0000, 1'b0, 1'b1);
    step(16'h3000, 16'd2, 1'b1, 1'b1);
    chk("t4_load_wins", {15'b0, TMR_IRQ}, 16'h0000);
    for (int k = 1; k <= 8; k++) begin
      step(16'h3001, 16'h0000, 1'b0, 1'b1);
      chk("t4_restart_irq", {15'b0, TMR_IRQ}, (k == 8) ? 16'd1 : 16'd0);
    end
    // Clear on the expiry edge: set wins.
    step(16'h3001, 16'h0000, 1'b1, 1'b1);
    chk("t4_pre_clear", {15'b0, TMR_IRQ}, 16'h0000);
    step(16'h3000, 16'd1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(16'h1000, 16'h0000, 1'b0, 1'b1);
    step(16'h3001, 16'h0000, 1'b1, 1'b1);
    chk("t4_set_wins", {15'b0, TMR_IRQ}, 16'h0001);

    // Reset mid-countdown.
    step(16'h1000, 16'h01FF, 1'b1, 1'b1);
    step(16'h2003, 16'h0033, 1'b1, 1'b1);
    step(16'h3000, 16'd5, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(16'h3000, 16'h0000, 1'b0, 1'b1);
    step(16'h3000, 16'h0000, 1'b0, 1'b0);
    chk("t6_led", {7'b0, LEDR}, 16'h0000);
    chk("t6_hex3", {9'b0, HEX3}, 16'h0000);
    chk("t6_din", DIN, 16'h0000);
    for (int k = 0; k < 30; k++) begin
      step(16'h3000, 16'h0000, 1'b0, 1'b1);
      chk("t6_count", DIN, 16'h0000);
      chk("t6_irq", {15'b0, TMR_IRQ}, 16'h0000);
    end

    // Random traffic against the model.
    for (int i = 0; i < 8; i++) step(16'(i), 16'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      a = 16'($urandom);
      a[15:12] = 4'($urandom_range(0, 4));
      if (a[15:12] == 4'h0) a[6:3] = 4'h0;
      w = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      if (a[15:12] == 4'h3 && !a[0]) d = 16'($urandom_range(0, 3));
      step(a, d, w, ($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
